bios_dl_sequencer: RTL and testbench

//  Sequences BIOS image download from data_io (ioctl byte stream) into the system BIOS write port.

---
 rtl/bios_dl_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_bios_dl_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bios_dl_sequencer.sv
// BIOS download sequencer: pairs ioctl bytes into 16-bit words, double-buffers them in two
// banks and offers each full bank to the system. Define BIOS_DL_INDEX_FILTER_EN to accept only ioctl_index==DL_INDEX.
module bios_dl_sequencer #(
  parameter int          BLOCK_WORDS = 64,
  parameter int          ADDR_W      = 13,
  parameter logic [15:0] PAD_WORD    = 16'hFFFF,
  parameter logic [7:0]  DL_INDEX    = 8'h00
) (
  input  logic              clk_sdr,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              bios_req,
  output logic [ADDR_W-1:0] bios_addr,
  output logic [15:0]       bios_din,
  output logic              bios_wr,
  output logic              bios_loaded,
  output logic              overrun
);

  localparam int             PW   = $clog2(BLOCK_WORDS);
  localparam logic [PW-1:0]  LAST = PW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_OFFER, R_GAP} rd_state_t;
  typedef enum logic [1:0] {LD_LOADING, LD_FLUSH, LD_DRAIN, LD_DONE} ld_state_t;

  rd_state_t rd_state, rd_state_nxt;
  ld_state_t ld_state, ld_state_nxt;

  logic [15:0]   mem [0:2*BLOCK_WORDS-1];
  logic          dl_q, dl_start, dl_end, dl_on;
  logic          wr_bank, rd_bank, low_vld;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    low_q;
  logic [1:0]    full, free_now, full_set;
  logic          wr_busy, byte_in, flush_wr, word_we, word_wrap, rd_take, nothing_pending;
  logic [15:0]   word_wd;
  logic          unused_ok;

  always_ff @(posedge clk_sdr or negedge reset_n) begin
    if (!reset_n) dl_q <= 1'b0;
    else          dl_q <= ioctl_download;
  end

`ifdef BIOS_DL_INDEX_FILTER_EN
  // The index is judged once, at the rising edge; a rejected download leaves everything untouched.
  logic acc_q;
  always_ff @(posedge clk_sdr or negedge reset_n) begin
    if (!reset_n)                      acc_q <= 1'b0;
    else if (ioctl_download && !dl_q)  acc_q <= (ioctl_index == DL_INDEX);
    else if (!ioctl_download)          acc_q <= 1'b0;
  end
  assign dl_start  = ioctl_download & ~dl_q & (ioctl_index == DL_INDEX);
  assign dl_end    = ~ioctl_download & dl_q & acc_q;
  assign dl_on     = ioctl_download & acc_q;
  assign unused_ok = &{1'b0, ioctl_addr[24:1]};
`else
  assign dl_start  = ioctl_download & ~dl_q;
  assign dl_end    = ~ioctl_download & dl_q;
  assign dl_on     = ioctl_download & dl_q;
  assign unused_ok = &{1'b0, ioctl_addr[24:1], ioctl_index, DL_INDEX};
`endif

  // A bank freed by the reader this cycle may take a byte in the same cycle.
  always_comb begin
    free_now = 2'b00;
    if (rd_take && rd_ptr == LAST) free_now[rd_bank] = 1'b1;
  end

  assign wr_busy         = full[wr_bank] & ~free_now[wr_bank];
  assign byte_in         = ioctl_wr & dl_on & (ld_state == LD_LOADING);
  assign flush_wr        = (ld_state == LD_FLUSH) & ~wr_busy & (low_vld | (wr_ptr != '0)) & ~dl_start;
  assign nothing_pending = (wr_ptr == '0) & ~low_vld & (full == 2'b00);

  always_comb begin
    word_we = 1'b0;
    word_wd = PAD_WORD;
    if (byte_in && !wr_busy && ioctl_addr[0]) begin
      word_we = 1'b1;
      word_wd = {ioctl_dout, low_q};
    end else if (flush_wr) begin
      word_we = 1'b1;
      word_wd = low_vld ? {PAD_WORD[15:8], low_q} : PAD_WORD;
    end
  end

  assign word_wrap = word_we & (wr_ptr == LAST);
  assign full_set  = {word_wrap & wr_bank, word_wrap & ~wr_bank};

  always_ff @(posedge clk_sdr) begin
    if (word_we) mem[{wr_bank, wr_ptr}] <= word_wd;
    if (byte_in && !wr_busy && !ioctl_addr[0]) low_q <= ioctl_dout;
  end

  always_ff @(posedge clk_sdr or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
      low_vld <= 1'b0;
      full    <= 2'b00;
      overrun <= 1'b0;
    end else if (dl_start) begin
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
      low_vld <= 1'b0;
      full    <= 2'b00;
      overrun <= 1'b0;
    end else begin
      full <= (full & ~free_now) | full_set;
      if (word_we) begin
        wr_ptr  <= wr_ptr + PW'(1);
        low_vld <= 1'b0;
      end else if (byte_in && !wr_busy && !ioctl_addr[0]) begin
        low_vld <= 1'b1;
      end
      if (word_wrap)          wr_bank <= ~wr_bank;
      if (byte_in && wr_busy) overrun <= 1'b1;
    end
  end

  assign rd_take = (rd_state == R_OFFER) & bios_req & ~dl_start;

  always_ff @(posedge clk_sdr or negedge reset_n) begin
    if (!reset_n) begin
      rd_bank   <= 1'b0;
      rd_ptr    <= '0;
      bios_addr <= '0;
      bios_din  <= 16'h0000;
    end else if (dl_start) begin
      rd_bank   <= 1'b0;
      rd_ptr    <= '0;
      bios_addr <= '0;
    end else if (rd_take) begin
      bios_din  <= mem[{rd_bank, rd_ptr}];
      rd_ptr    <= rd_ptr + PW'(1);
      bios_addr <= bios_addr + ADDR_W'(1);
      if (rd_ptr == LAST) rd_bank <= ~rd_bank;
    end
  end

  always_ff @(posedge clk_sdr or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= R_IDLE;
      ld_state <= LD_LOADING;
    end else begin
      rd_state <= rd_state_nxt;
      ld_state <= ld_state_nxt;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    if (dl_start) begin
      rd_state_nxt = R_IDLE;
    end else begin
      unique case (rd_state)
        R_IDLE:  if (full[rd_bank]) rd_state_nxt = R_OFFER;
        R_OFFER: if (rd_take && rd_ptr == LAST) rd_state_nxt = R_GAP;
        // One low cycle between offers so the consumer sees a fresh rising edge.
        R_GAP:   rd_state_nxt = full[rd_bank] ? R_OFFER : R_IDLE;
        default: rd_state_nxt = R_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_state_nxt = ld_state;
    if (dl_start) begin
      ld_state_nxt = LD_LOADING;
    end else begin
      unique case (ld_state)
        LD_LOADING: if (dl_end) ld_state_nxt = nothing_pending ? LD_DONE : LD_FLUSH;
        LD_FLUSH:   if (!wr_busy && !low_vld && wr_ptr == '0) ld_state_nxt = LD_DRAIN;
        LD_DRAIN:   if (full == 2'b00) ld_state_nxt = LD_DONE;
        default:    ld_state_nxt = ld_state;
      endcase
    end
  end

  always_comb begin
    bios_wr     = (rd_state == R_OFFER);
    bios_loaded = (ld_state == LD_DONE);
  end

endmodule

// File: tb/tb_bios_dl_sequencer.sv
// Directed bench for bios_dl_sequencer: full image, partial tail, overrun, reset abort, index handling.
module tb_bios_dl_sequencer;

  logic        clk_sdr = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        bios_req;
  logic [12:0] bios_addr;
  logic [15:0] bios_din;
  logic        bios_wr;
  logic        bios_loaded;
  logic        overrun;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] got_q[$];
  logic        take_q  = 1'b0;
  logic        wr_prev = 1'b0;
  int          offers  = 0;
  int          low_run = 0;
  int          min_gap = 999;

  bios_dl_sequencer dut (
    .clk_sdr        (clk_sdr),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .bios_req       (bios_req),
    .bios_addr      (bios_addr),
    .bios_din       (bios_din),
    .bios_wr        (bios_wr),
    .bios_loaded    (bios_loaded),
    .overrun        (overrun)
  );

  always #5 clk_sdr = ~clk_sdr;

  // Consumer model: a word requested in one cycle appears on bios_din after the next edge.
  always @(negedge clk_sdr) begin
    if (take_q) got_q.push_back(bios_din);
    take_q = bios_wr & bios_req;
    if (bios_wr && !wr_prev) begin
      offers++;
      if (offers > 1 && low_run < min_gap) min_gap = low_run;
    end
    low_run = bios_wr ? 0 : low_run + 1;
    wr_prev = bios_wr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (i < got_q.size()) ? {16'h0, got_q[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk_sdr);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    offers  = 0;
    min_gap = 999;
  endtask

  task automatic begin_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_bytes(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i);
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
      tick();
    end
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wait_loaded(input string tag);
    for (int i = 0; i < 3000 && !bios_loaded; i++) tick();
    chk(tag, {31'h0, bios_loaded}, 32'd1);
    tick();
    tick();
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = 8'h00;
    bios_req       = 1'b0;
    tick();
    tick();
    chk("rst_addr",    {19'h0, bios_addr}, 32'd0);
    chk("rst_din",     {16'h0, bios_din},  32'd0);
    chk("rst_wr",      {31'h0, bios_wr},   32'd0);
    chk("rst_loaded",  {31'h0, bios_loaded}, 32'd0);
    chk("rst_overrun", {31'h0, overrun},   32'd0);
    reset_n = 1'b1;
    tick();

    // Full 256-byte image, consumer always ready.
    clear_mon();
    bios_req = 1'b1;
    begin_dl(8'h00);
    send_bytes(0, 256);
    end_dl();
    wait_loaded("t1_loaded");
    chk("t1_words",  got_q.size(), 32'd128);
    chk("t1_w0",     word_at(0),   32'h0100);
    chk("t1_w63",    word_at(63),  32'h7F7E);
    chk("t1_w64",    word_at(64),  32'h8180);
    chk("t1_w127",   word_at(127), 32'hFFFE);
    chk("t1_addr",   {19'h0, bios_addr}, 32'd128);
    chk("t1_offers", offers, 32'd2);
    chk("t1_gap_ge1", {31'h0, min_gap >= 1}, 32'd1);
    chk("t1_overrun", {31'h0, overrun}, 32'd0);

    // 131 bytes: odd tail byte and padded second bank.
    clear_mon();
    begin_dl(8'h00);
    chk("t2_loaded_clr", {31'h0, bios_loaded}, 32'd0);
    chk("t2_addr_clr",   {19'h0, bios_addr}, 32'd0);
    send_bytes(0, 131);
    end_dl();
    wait_loaded("t2_loaded");
    chk("t2_words", got_q.size(), 32'd128);
    chk("t2_w64",   word_at(64),  32'h8180);
    chk("t2_w65",   word_at(65),  32'hFF82);
    begin
      int pads = 0;
      for (int i = 66; i < 128; i++) if (word_at(i) == 32'hFFFF) pads++;
      chk("t2_pad_count", pads, 32'd62);
    end
    chk("t2_addr", {19'h0, bios_addr}, 32'd128);

    // Consumer stalled: both banks fill, byte 257 overruns, bank 0 stays intact.
    clear_mon();
    bios_req = 1'b0;
    begin_dl(8'h00);
    send_bytes(0, 256);
    chk("t3_no_overrun", {31'h0, overrun}, 32'd0);
    chk("t3_wr_held",    {31'h0, bios_wr}, 32'd1);
    send_bytes(256, 1);
    chk("t3_overrun", {31'h0, overrun}, 32'd1);
    send_bytes(257, 127);
    chk("t3_wr_still", {31'h0, bios_wr}, 32'd1);
    end_dl();
    bios_req = 1'b1;
    wait_loaded("t3_loaded");
    chk("t3_words",   got_q.size(), 32'd128);
    chk("t3_w0",      word_at(0),   32'h0100);
    chk("t3_w127",    word_at(127), 32'hFFFE);
    chk("t3_gap1",    min_gap,      32'd1);
    chk("t3_sticky",  {31'h0, overrun}, 32'd1);

    // Reset while a bank is on offer, then a clean restart.
    clear_mon();
    bios_req = 1'b0;
    begin_dl(8'h00);
    send_bytes(0, 130);
    chk("t4_offer", {31'h0, bios_wr}, 32'd1);
    bios_req = 1'b1;
    tick();
    tick();
    tick();
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_sdr);
    chk("t4_rst_outs", {bios_addr, bios_din, bios_wr, bios_loaded, overrun}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    clear_mon();
    begin_dl(8'h00);
    send_bytes(0, 256);
    end_dl();
    wait_loaded("t4_loaded");
    chk("t4_w0",   word_at(0), 32'h0100);
    chk("t4_addr", {19'h0, bios_addr}, 32'd128);

    // Download slot index handling.
`ifdef BIOS_DL_INDEX_FILTER_EN
    clear_mon();
    begin_dl(8'h01);
    send_bytes(0, 4);
    end_dl();
    for (int i = 0; i < 200; i++) tick();
    chk("t5_ign_offers", offers, 32'd0);
    chk("t5_ign_loaded", {31'h0, bios_loaded}, 32'd1);
    chk("t5_ign_addr",   {19'h0, bios_addr}, 32'd128);
    clear_mon();
    begin_dl(8'h00);
`else
    clear_mon();
    begin_dl(8'h01);
`endif
    send_bytes(0, 4);
    end_dl();
    wait_loaded("t5_loaded");
    chk("t5_w0",   word_at(0), 32'h0100);
    chk("t5_w1",   word_at(1), 32'h0302);
    chk("t5_w2",   word_at(2), 32'hFFFF);
    chk("t5_addr", {19'h0, bios_addr}, 32'd64);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
